shifter_pipe: RTL and testbench
===============================

# shifter_pipe

Parametrised, pipelined barrel shifter for the ALU datapath. It supports logical left, logical right, arithmetic right and (optionally) rotate right, selected by the 6-bit function code. Each of the log2(WIDTH) shift levels is registered, with a valid/ready handshake and backpressure. It accepts one operation per cycle and returns results in issue order with a pass-through tag.

## Interface
Parameters:
- WIDTH, 32: data width; power of two, 8..64.
- TAG_W, 4: width of the side-band tag carried alongside each operation.
- LEVELS, $clog2(WIDTH): derived; number of shift levels and pipeline registers.

Ports:
- clk  in  1  the single clock; all state is updated on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  an operation is offered on the input.
- in_ready  out  1  the block can accept the offered operation this cycle.
- Signal  in  6  function code: SLL 6'h00, SRL 6'h02, SRA 6'h03, ROR 6'h06.
- a  in  WIDTH  operand to be shifted.
- shamt  in  LEVELS  shift amount, unsigned.
- in_tag  in  TAG_W  opaque tag, returned unchanged with the result.
- out_valid  out  1  a result is presented on the output.
- out_ready  in  1  the consumer accepts the presented result.
- result  out  WIDTH  shifted data.
- out_tag  out  TAG_W  tag of the operation that produced result.
- out_err  out  1  the function code was illegal.

## Operation
- Transfer rule: an operation is accepted when in_valid && in_ready; a result is consumed when out_valid && out_ready.
- Pipeline structure: LEVELS register stages. Stage i applies a shift of 2^i when shamt[i]=1; stages are ordered LSB first.
- Side-band state: each stage carries a valid bit, the function code, the remaining shamt bits, the tag and the original operand MSB (the SRA fill bit).
- Pipeline enable: en = out_ready || !out_valid. All stages advance together when en=1 and hold when en=0 (global stall). in_ready = en.
- Bubbles: a stage with valid=0 still advances, so bubbles collapse naturally and no state machine is needed.
- SLL: vacated LSBs are filled with 0.
- SRL: vacated MSBs are filled with 0.
- SRA: vacated MSBs are filled with the original a[WIDTH-1].
- ROR: bits shifted out of the LSB re-enter at the MSB.
- Zero shift: shamt=0 returns a unchanged in every legal mode.
- Illegal code: any other Signal value gives result=a, out_err=1 and the same latency; the operation is never dropped.
- Ordering and loss: results emerge in acceptance order. No operation is lost or duplicated under any pattern of stalls.

## Timing
- Reset values: in_ready=0 while rst_n=0 and 1 at the first edge after release. out_valid=0, result=0, out_tag=0, out_err=0. All stage valid bits are 0.
- Latency: an operation accepted at edge k appears with out_valid=1 after edge k+LEVELS when no stall occurs (5 cycles for WIDTH=32).
- Throughput: 1 operation per cycle while out_ready is held at 1.
- Stall: when out_valid=1 and out_ready=0, every stage holds and in_ready=0 in that same cycle (combinational path from out_ready).
- Output stability: result, out_tag and out_err stay constant while out_valid && !out_ready.
- Simultaneous consume and accept: allowed in the same cycle; the pipeline shifts by one stage.
- Reset mid-operation: asserting rst_n clears all valid bits immediately, asynchronously. In-flight operations are discarded and never appear after release.

## Configuration
- Macro SHIFTER_ROTATE_EN.
- Defined: ROR (6'h06) is legal and rotates right by shamt.
- Undefined: 6'h06 is treated as illegal (result=a, out_err=1), and the wrap-around path is not built.

## Structure
- Package shifter_pkg holds:
  - the function-code localparams FUNCT_SLL, FUNCT_SRL, FUNCT_SRA, FUNCT_ROR;
  - a mode enum {MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROR, MODE_ILL};
  - a decode function mapping Signal to mode.
- Sub-module shift_stage (parameters WIDTH, DIST) implements one registered level: mux plus the data, tag, mode, fill-bit and valid registers, with an enable input. shifter_pipe instantiates LEVELS copies via generate.

## Test plan
- SRL: a=0x80000000, shamt=31, WIDTH=32 -> result=0x00000001 exactly 5 cycles after acceptance, out_err=0, tag preserved.
- SRA and SLL: SRA a=0x80000000, shamt=4 -> 0xF8000000; SRA a=0x40000000, shamt=4 -> 0x04000000; SLL a=0x00000001, shamt=31 -> 0x80000000.
- ROR and illegal code:
  - With SHIFTER_ROTATE_EN: a=0x00000001, shamt=1 -> 0x80000000; a=0x12345678, shamt=8 -> 0x78123456.
  - Without the macro: the same ROR operations -> out_err=1, result=a.
  - Signal=6'h3F -> out_err=1.
- Backpressure: issue 8 back-to-back operations with tags 0..7 and drop out_ready during cycles 6-9 -> in_ready=0 during the stall, all 8 results delivered in tag order, result held stable while stalled.
- Reset mid-operation: reset with 3 operations in flight -> out_valid=0 and all outputs 0 immediately; nothing emerges after release; a new operation completes with normal latency.
- WIDTH=8 instance: LEVELS=3 and latency is 3 cycles. SRA a=0x90, shamt=2 -> 0xE4. shamt=0 in all modes -> identity.

Source files
------------

// File: rtl/shifter_pkg.sv
// Function codes, internal shift modes and the code-to-mode decoder for shifter_pipe.
// Combinational only; no latency, no flow control.
// ROR decodes as legal only when SHIFTER_ROTATE_EN is defined.
package shifter_pkg;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_SRA = 6'h03;
    localparam logic [5:0] FUNCT_ROR = 6'h06;

    typedef enum logic [2:0] {
        MODE_SLL,
        MODE_SRL,
        MODE_SRA,
        MODE_ROR,
        MODE_ILL
    } mode_t;

    function automatic mode_t decode_funct(input logic [5:0] funct);
        mode_t m;
        case (funct)
            FUNCT_SLL: m = MODE_SLL;
            FUNCT_SRL: m = MODE_SRL;
            FUNCT_SRA: m = MODE_SRA;
`ifdef SHIFTER_ROTATE_EN
            FUNCT_ROR: m = MODE_ROR;
`endif
            default:   m = MODE_ILL;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered barrel-shifter level: shifts by DIST when its shamt bit is set.
// Latency 1 cycle; the side-band (valid, mode, shamt, fill, tag) travels with the data.
// Backpressure: holds every register while en=0; bubbles advance like data when en=1.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1,
    parameter int TAG_W = 4,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_vld,
    input  mode_t            in_mode,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_fill,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    output mode_t            out_mode,
    output logic [SHW-1:0]   out_shamt,
    output logic             out_fill,
    output logic [TAG_W-1:0] out_tag,
    output logic [WIDTH-1:0] out_dat
);

    localparam int BIT = $clog2(DIST);

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = in_dat;
        if (in_shamt[BIT]) begin
            case (in_mode)
                MODE_SLL: shifted = in_dat << DIST;
                MODE_SRL: shifted = in_dat >> DIST;
                // fill comes from the original operand MSB, not the partially shifted word
                MODE_SRA: shifted = {{DIST{in_fill}}, in_dat[WIDTH-1:DIST]};
`ifdef SHIFTER_ROTATE_EN
                MODE_ROR: shifted = {in_dat[DIST-1:0], in_dat[WIDTH-1:DIST]};
`endif
                default:  shifted = in_dat;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld   <= 1'b0;
            out_mode  <= MODE_SLL;
            out_shamt <= '0;
            out_fill  <= 1'b0;
            out_tag   <= '0;
            out_dat   <= '0;
        end else if (en) begin
            out_vld   <= in_vld;
            out_mode  <= in_mode;
            out_shamt <= in_shamt;
            out_fill  <= in_fill;
            out_tag   <= in_tag;
            out_dat   <= shifted;
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA, ROR when SHIFTER_ROTATE_EN is defined).
// Latency LEVELS cycles, one operation per cycle, results in issue order with tag.
// Backpressure: global stall, in_ready = out_ready || !out_valid (combinational).
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int TAG_W  = 4,
    parameter int LEVELS = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        Signal,
    input  logic [WIDTH-1:0]  a,
    input  logic [LEVELS-1:0] shamt,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    logic              vld   [0:LEVELS];
    mode_t             mode  [0:LEVELS];
    logic [LEVELS-1:0] sh    [0:LEVELS];
    logic              fill  [0:LEVELS];
    logic [TAG_W-1:0]  tag   [0:LEVELS];
    logic [WIDTH-1:0]  dat   [0:LEVELS];

    logic en;
    logic rdy_q;

    // keeps in_ready low during reset even though the empty pipe would allow entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    assign en       = out_ready || !out_valid;
    assign in_ready = en && rdy_q;

    assign vld[0]  = in_valid && in_ready;
    assign mode[0] = decode_funct(Signal);
    assign sh[0]   = shamt;
    assign fill[0] = a[WIDTH-1];
    assign tag[0]  = in_tag;
    assign dat[0]  = a;

    for (genvar i = 0; i < LEVELS; i++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << i),
            .TAG_W (TAG_W),
            .SHW   (LEVELS)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_vld    (vld[i]),
            .in_mode   (mode[i]),
            .in_shamt  (sh[i]),
            .in_fill   (fill[i]),
            .in_tag    (tag[i]),
            .in_dat    (dat[i]),
            .out_vld   (vld[i+1]),
            .out_mode  (mode[i+1]),
            .out_shamt (sh[i+1]),
            .out_fill  (fill[i+1]),
            .out_tag   (tag[i+1]),
            .out_dat   (dat[i+1])
        );
    end

    assign out_valid = vld[LEVELS];
    assign result    = dat[LEVELS];
    assign out_tag   = tag[LEVELS];
    assign out_err   = (mode[LEVELS] == MODE_ILL);

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed bench for shifter_pipe: a WIDTH=32 and a WIDTH=8 instance on one clock.
module tb_shifter_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, out_err;
    logic [5:0]  funct = '0;
    logic [31:0] a = '0, result;
    logic [4:0]  shamt = '0;
    logic [3:0]  in_tag = '0, out_tag;

    logic        b_in_valid = 1'b0, b_out_ready = 1'b1;
    logic        b_in_ready, b_out_valid, b_out_err;
    logic [5:0]  b_funct = '0;
    logic [7:0]  b_a = '0, b_result;
    logic [2:0]  b_shamt = '0;
    logic [3:0]  b_in_tag = '0, b_out_tag;

    int tests = 0;
    int fails = 0;

    shifter_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Signal(funct), .a(a), .shamt(shamt), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_tag(out_tag), .out_err(out_err)
    );

    shifter_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .Signal(b_funct), .a(b_a), .shamt(b_shamt), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_result),
        .out_tag(b_out_tag), .out_err(b_out_err)
    );

`ifdef SHIFTER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One isolated op on the 32-bit instance; latency counted in rising edges from acceptance.
    task automatic run32(input string name, input logic [5:0] f, input logic [31:0] av,
                         input logic [4:0] sh, input logic [3:0] tg,
                         input logic [31:0] exp_r, input logic exp_e);
        int n;
        @(negedge clk);
        funct = f; a = av; shamt = sh; in_tag = tg; in_valid = 1'b1;
        #1;
        check({name, ".in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, ".latency"}, n, 5);
        check({name, ".result"}, result, exp_r);
        check({name, ".tag"}, out_tag, tg);
        check({name, ".err"}, out_err, exp_e);
    endtask

    task automatic run8(input string name, input logic [5:0] f, input logic [7:0] av,
                        input logic [2:0] sh, input logic [3:0] tg,
                        input logic [7:0] exp_r, input logic exp_e);
        int n;
        @(negedge clk);
        b_funct = f; b_a = av; b_shamt = sh; b_in_tag = tg; b_in_valid = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        n = 1;
        while (!b_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, ".latency"}, n, 3);
        check({name, ".result"}, b_result, exp_r);
        check({name, ".tag"}, b_out_tag, tg);
        check({name, ".err"}, b_out_err, exp_e);
    endtask

    logic [31:0] exp_q [8];
    logic [31:0] held;
    int issued, got, seen;
    bit stalled_prev;

    initial begin
        // reset state
        #2;
        check("rst.in_ready", in_ready, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.result", result, 0);
        check("rst.out_tag", out_tag, 0);
        check("rst.out_err", out_err, 0);
        check("rst.b_in_ready", b_in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel.in_ready_before_edge", in_ready, 0);
        @(negedge clk);
        check("rel.in_ready_after_edge", in_ready, 1);

        // main function, 32-bit
        run32("srl31", 6'h02, 32'h8000_0000, 5'd31, 4'h5, 32'h0000_0001, 1'b0);
        run32("sra_neg", 6'h03, 32'h8000_0000, 5'd4, 4'h6, 32'hF800_0000, 1'b0);
        run32("sra_pos", 6'h03, 32'h4000_0000, 5'd4, 4'h7, 32'h0400_0000, 1'b0);
        run32("sll31", 6'h00, 32'h0000_0001, 5'd31, 4'h8, 32'h8000_0000, 1'b0);
        run32("srl0", 6'h02, 32'hCAFE_F00D, 5'd0, 4'h9, 32'hCAFE_F00D, 1'b0);
        run32("ror1", 6'h06, 32'h0000_0001, 5'd1, 4'hA,
              ROT ? 32'h8000_0000 : 32'h0000_0001, !ROT);
        run32("ror8", 6'h06, 32'h1234_5678, 5'd8, 4'hB,
              ROT ? 32'h7812_3456 : 32'h1234_5678, !ROT);
        run32("ill3f", 6'h3F, 32'hDEAD_BEEF, 5'd3, 4'hC, 32'hDEAD_BEEF, 1'b1);

        // backpressure: 8 back-to-back ops, out_ready low for cycles 6..9
        issued = 0; got = 0; stalled_prev = 1'b0; held = '0;
        for (int i = 0; i < 8; i++) exp_q[i] = (32'(i) + 32'd1) << i;
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 6 && c <= 9);
            #1;
            if (out_valid && !out_ready) begin
                check("bp.in_ready_stall", in_ready, 0);
                if (stalled_prev) check("bp.result_hold", result, held);
                held = result;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                check("bp.tag_order", out_tag, got);
                check("bp.result", result, exp_q[got]);
                got++;
            end
            if (issued < 8 && in_ready) begin
                funct = 6'h00; a = 32'(issued) + 32'd1; shamt = 5'(issued);
                in_tag = 4'(issued); in_valid = 1'b1;
                issued++;
            end else begin
                in_valid = 1'b0;
            end
        end
        check("bp.delivered", got, 8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(negedge clk);

        // reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            funct = 6'h00; a = 32'h1; shamt = 5'd1; in_tag = 4'(i + 1); in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst.out_valid", out_valid, 0);
        check("mrst.result", result, 0);
        check("mrst.out_tag", out_tag, 0);
        check("mrst.out_err", out_err, 0);
        check("mrst.in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mrst.nothing_after_release", seen, 0);
        run32("mrst.new_op", 6'h00, 32'h0000_0003, 5'd2, 4'h3, 32'h0000_000C, 1'b0);

        // 8-bit instance
        run8("w8.sra2", 6'h03, 8'h90, 3'd2, 4'h1, 8'hE4, 1'b0);
        run8("w8.sll0", 6'h00, 8'hA5, 3'd0, 4'h2, 8'hA5, 1'b0);
        run8("w8.srl0", 6'h02, 8'hA5, 3'd0, 4'h3, 8'hA5, 1'b0);
        run8("w8.sra0", 6'h03, 8'hA5, 3'd0, 4'h4, 8'hA5, 1'b0);
        run8("w8.ror0", 6'h06, 8'hA5, 3'd0, 4'h5, 8'hA5, !ROT);
        run8("w8.sll1", 6'h00, 8'h81, 3'd1, 4'h6, 8'h02, 1'b0);
        run8("w8.srl7", 6'h02, 8'h81, 3'd7, 4'h7, 8'h01, 1'b0);
        run8("w8.ror3", 6'h06, 8'h81, 3'd3, 4'h8, ROT ? 8'h30 : 8'h81, !ROT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
